// File: rtl/dac_level_ctrl.sv
// dac_level_ctrl: per-channel saturating DAC level registers with a
// round-robin write scheduler driving the dactrig/dacdone handshake.
// Optional feature macro: DAC_LEVEL_POWERUP_LOAD_EN (dirty bits reset to
// all ones, so INIT is written to every channel after reset release).
//
// state  | meaning
// S_IDLE  | no write outstanding; select next dirty channel round-robin
// S_ISSUE | data/address latched; dactrig is raised on the next edge
// S_WAIT  | write in flight; wait for dacdone
module dac_level_ctrl #(
  parameter int              DATA_W   = 12,
  parameter int              CHANNELS = 4,
  parameter int              STEP     = 32,
  parameter logic [DATA_W-1:0] INIT   = {1'b1, {(DATA_W-1){1'b0}}},
  parameter logic [3:0]      CMD      = 4'b0011,
  parameter int              CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              CLK50MHZ,
  input  logic              RST_N,
  input  logic [CH_W-1:0]   sel,
  input  logic              less,
  input  logic              more,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        address,
  output logic [3:0]        command,
  output logic              dactrig,
  input  logic              dacdone,
  output logic              busy,
  output logic [7:0]        LED
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [DATA_W:0] STEP_X = (DATA_W+1)'(STEP);

`ifdef DAC_LEVEL_POWERUP_LOAD_EN
  localparam logic [CHANNELS-1:0] DIRTY_RST = '1;
`else
  localparam logic [CHANNELS-1:0] DIRTY_RST = '0;
`endif

  state_t              state;
  logic [DATA_W-1:0]   lvl [CHANNELS];
  logic [CHANNELS-1:0] dirty;
  logic [CHANNELS-1:0] dirty_nxt;
  logic [CH_W-1:0]     last;
  logic [CH_W-1:0]     cur;
  logic [CH_W-1:0]     pick;
  logic                pick_vld;
  logic [DATA_W-1:0]   pick_lvl;
  logic                sel_ok;
  logic                upd;
  logic [DATA_W-1:0]   sel_lvl;
  logic [DATA_W-1:0]   lvl_new;
  logic [DATA_W:0]     sum;

  // Decode sel against the real channel count and fetch its level.
  always_comb begin
    sel_ok  = 1'b0;
    sel_lvl = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == CH_W'(i)) begin
        sel_ok  = 1'b1;
        sel_lvl = lvl[i];
      end
    end
  end

  // Saturating step of the selected level; both pulses together cancel.
  always_comb begin
    upd = sel_ok & (less ^ more);
    sum = {1'b0, sel_lvl} + STEP_X;
    if (more)
      lvl_new = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    else
      lvl_new = ({1'b0, sel_lvl} >= STEP_X) ? sel_lvl - STEP_X[DATA_W-1:0] : '0;
  end

  // Round-robin search for the next dirty channel, starting after last.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    pick_lvl = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(last) + k) % CHANNELS;
      if (!pick_vld && dirty[idx]) begin
        pick_vld = 1'b1;
        pick     = CH_W'(idx);
        pick_lvl = lvl[idx];
      end
    end
  end

  // Dirty bits: a fresh update outranks the clear done at selection.
  always_comb begin
    dirty_nxt = dirty;
    if (state == S_IDLE && pick_vld)
      dirty_nxt[pick] = 1'b0;
    if (upd)
      dirty_nxt[sel] = 1'b1;
  end

  // Level registers, one per channel.
  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < CHANNELS; i++) lvl[i] <= INIT;
    end else if (upd) begin
      for (int i = 0; i < CHANNELS; i++)
        if (sel == CH_W'(i)) lvl[i] <= lvl_new;
    end
  end

  // Write scheduler FSM with registered handshake outputs.
  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      dirty   <= DIRTY_RST;
      last    <= CH_W'(CHANNELS - 1);
      cur     <= '0;
      data    <= '0;
      address <= '0;
      command <= CMD;
      dactrig <= 1'b0;
      busy    <= 1'b0;
    end else begin
      dirty   <= dirty_nxt;
      command <= CMD;
      dactrig <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            data    <= pick_lvl;
            address <= 4'(pick);
            cur     <= pick;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          dactrig <= 1'b1;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (dacdone) begin
            last  <= cur;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // LED shows the top of the selected level; narrow codes pad on the right.
  generate
    if (DATA_W >= 8) begin : g_led_wide
      assign LED = sel_lvl[DATA_W-1 -: 8];
    end else begin : g_led_narrow
      assign LED = {sel_lvl, {(8-DATA_W){1'b0}}};
    end
  endgenerate

endmodule

// File: doc/dac_level_ctrl.md
# dac_level_ctrl

Parametrised multi-channel level controller for the SPI DAC path: holds one saturating level register per DAC channel, steps the selected channel up or down on single-cycle `less`/`more` pulses, and schedules writes to the DAC driver through the existing `dactrig`/`dacdone` handshake. It sits between the debounced button logic and the DAC SPI driver. It replaces the fixed-value, single-channel controller with per-channel state, correct saturation and a queue of pending updates.

## Interface
- `DATA_W`, 12: DAC code width, 2..16.
- `CHANNELS`, 4: number of level registers / DAC channels, 1..16.
- `STEP`, 32: increment/decrement per pulse, 1..2^DATA_W-1.
- `INIT`, 2^(DATA_W-1): reset value of every level register.
- `CMD`, 4'b0011: command code emitted with every write (write and update channel n).
- `CH_W`, clog2(CHANNELS), minimum 1: derived width of `sel`.

- `CLK50MHZ`  in  1  system clock, all logic on its rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `sel`  in  CH_W  channel targeted by `less`/`more`. Values >= CHANNELS are ignored.
- `less`  in  1  single-cycle pulse: decrement `sel` channel by STEP.
- `more`  in  1  single-cycle pulse: increment `sel` channel by STEP.
- `data`  out  DATA_W  code for the current write. Held stable from `dactrig` until `dacdone`.
- `address`  out  4  DAC channel address (channel index, zero-extended).
- `command`  out  4  always CMD.
- `dactrig`  out  1  one-cycle start pulse to the DAC driver.
- `dacdone`  in  1  one-cycle completion pulse from the DAC driver.
- `busy`  out  1  high while a write is outstanding (ISSUE or WAIT).
- `LED`  out  8  top 8 bits of the `sel` channel level, zero-padded on the LSB side if DATA_W < 8.

## Operation
- **Level update:** occurs on a rising edge with exactly one of `less`/`more` high and `sel` < CHANNELS.
  - `more`: `lvl[sel] <= min(lvl[sel] + STEP, 2^DATA_W-1)`. Compute in DATA_W+1 bits.
  - `less`: `lvl[sel] <= (lvl[sel] >= STEP) ? lvl[sel] - STEP : 0`.
  - Both pulses high: no change and no dirty set.
- **Dirty tracking:** each successful update sets `dirty[sel]`, including a saturated update that leaves the value unchanged.
- **FSM states:**
  - IDLE: if any dirty bit is set, pick a channel by round-robin starting at `last+1` mod CHANNELS. Latch `lvl[ch]` into `data` and `ch` into `address`, clear `dirty[ch]`, go to ISSUE.
  - ISSUE: `dactrig`=1 for this one cycle, go to WAIT.
  - WAIT: stay until `dacdone`=1, then set `last <= ch` and go to IDLE.
- **Update during a write:** an update to the channel being written re-sets its dirty bit. A set takes priority over the clear performed in IDLE in the same cycle. The new value is written in a later transaction. `data` never changes mid-write.
- **Handshake:** a `dacdone` pulse outside WAIT is ignored.
- **Reset values:**
  - `lvl[*]`=INIT, `dirty`=0, `last`=CHANNELS-1, state=IDLE.
  - `data`=0, `address`=0, `command`=CMD, `dactrig`=0, `busy`=0.
- **Reset mid-write:** asserting `RST_N` low aborts the transaction immediately; no further `dactrig` is issued.

## Timing
- An update pulse at edge N updates `lvl` and `dirty` at N. `LED` reflects the new value after N.
- With the FSM idle, the channel is selected at N+1 and `dactrig` is high during the cycle after edge N+2.
- `busy` is high from the selection edge through the edge that samples `dacdone`.
- Minimum spacing between successive `dactrig` pulses is 3 cycles: `dacdone` at edge M, IDLE select at M+1, `dactrig` after M+2.
- Every output is registered; no combinational path from any input to any output except `sel` -> `LED`.

## Configuration
- `DAC_LEVEL_POWERUP_LOAD_EN`
  - Defined: reset sets `dirty` to all ones, so after reset release the block writes INIT to every channel, in order 0..CHANNELS-1.
  - Undefined: `dirty` resets to 0 and no writes occur until the first update.

## Test plan
- Reset, macro undefined, DATA_W=12, STEP=32: `LED`=8'h80, `dactrig` never pulses over 100 cycles, `command`=4'b0011.
- `sel`=2, one `more` pulse, driver returns `dacdone` 10 cycles after `dactrig` -> one `dactrig`, `address`=2, `data`=12'h820, `busy` falls after `dacdone`.
- Saturation: with `lvl[1]`=12'hFF0, a `more` pulse -> `data`=12'hFFF. With `lvl[1]`=12'h010, a `less` pulse -> 12'h000. `less` and `more` together -> no change and no `dactrig`.
- Updates on channels 3, 0, 1 during one long WAIT -> subsequent writes served round-robin after the current channel. A second `more` on the in-flight channel during WAIT -> that channel is rewritten with the newer value.
- Reset asserted during WAIT -> `dactrig`, `busy` and `data` go to 0 asynchronously, and all levels return to INIT.
- Macro defined, CHANNELS=4 -> four writes with `address` 0,1,2,3, each with `data`=12'h800, on the `dacdone` handshake after reset release.
